// File: rtl/vedic_mul_result_streamer.sv
// vedic_mul_result_streamer: captures one product and streams it LSW-first as WORD_W beats with a last flag.
// Defining RESULT_STREAMER_PARITY_EN adds out_parity, the XOR of the current beat.
module vedic_mul_result_streamer #(
    parameter int PROD_W = 512,
    parameter int WORD_W = 32,
    localparam int NUM_WORDS = PROD_W / WORD_W,
    localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy
`ifdef RESULT_STREAMER_PARITY_EN
    ,
    output logic              out_parity
`endif
);
    if (PROD_W % WORD_W != 0) begin : g_bad_width
        $error("WORD_W must divide PROD_W");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] shadow_q, shadow_d;
    logic                             capture;

    assign out_valid  = state_q == STREAM;
    assign busy       = out_valid;
    assign out_idx    = idx_q;
    assign out_last   = out_valid && idx_q == IDX_W'(NUM_WORDS - 1);
    assign out_data   = out_valid ? shadow_q[idx_q] : '0;
    // Ready is forced low in reset and opens on the final beat so products chain without bubbles.
    assign prod_ready = !rst && (state_q == IDLE || (out_last && out_ready));
    assign capture    = prod_valid && prod_ready;
`ifdef RESULT_STREAMER_PARITY_EN
    assign out_parity = ^out_data;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (out_valid && out_ready) begin
            if (out_last) state_d = IDLE;
            else          idx_d   = idx_q + IDX_W'(1);
        end
        if (capture) begin
            shadow_d = prod;
            idx_d    = '0;
            state_d  = STREAM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end
endmodule
